cache_line_store: RTL and testbench
===================================

Name: cache_line_store

Overview:
- 2-way set-associative line storage and miss controller for the LC-3b L1 cache.
- Holds tags, valid, dirty and LRU state plus both ways' 128-bit lines. Resolves hits and runs writeback/fill against physical memory.
- Presents the indexed set's two lines, the hit way and the byte offset to the downstream read-data selection mux.

Parameters:
- SET_BITS, 3, index width; the block has 2^SET_BITS sets. Tag width is 12-SET_BITS, so 9 at the default.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_address  in  16  CPU byte address: offset [3:0], index [3+SET_BITS:4], tag [15:4+SET_BITS].
- mem_read  in  1  CPU read request; level-held until mem_resp.
- mem_write  in  1  CPU write request; level-held until mem_resp.
- mem_wdata  in  16  write word.
- mem_byte_enable  in  2  write byte lanes; bit0 is the low byte.
- mem_resp  out  1  request complete; 1-cycle pulse per request.
- way0_data  out  128  way0 line of the indexed set.
- way1_data  out  128  way1 line of the indexed set.
- hit_way  out  1  way that hit; 0 when there is no hit.
- byte_offset  out  4  equals mem_address[3:0].
- pmem_address  out  16  line address, low 4 bits always 0.
- pmem_read  out  1  fill request; held until pmem_resp.
- pmem_write  out  1  writeback request; held until pmem_resp.
- pmem_wdata  out  128  victim line.
- pmem_rdata  in  128  fill line.
- pmem_resp  in  1  physical memory done; 1-cycle pulse.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All valid, dirty, LRU bits and data/tag arrays clear to 0; state goes to CHECK.
  - mem_resp, pmem_read, pmem_write and hit_way go to 0; pmem_address and pmem_wdata go to 0.
  - A reset during WRITEBACK or FILL aborts it; pmem requests drop immediately.
- Array reads are asynchronous, indexed by mem_address index. way0_data and way1_data are combinational from the arrays.
- hit[w] = valid[w] & tag[w]==tag(mem_address). If both ways match, which is illegal, way0 wins.
- State CHECK:
  - With no request, all outputs are idle.
  - Request that hits: mem_resp=1 combinationally in the same cycle, hit_way=hit way.
    - Read hit: no state change except LRU.
    - Write hit: at the clock edge, write mem_wdata into 16-bit word mem_address[3:1] of the hit line, only lanes with byte_enable=1. Set dirty.
  - Every hit sets lru[index] to ~hit_way at that edge.
  - mem_read and mem_write both high is treated as a write.
  - Request that misses: choose a victim.
    - If any way is invalid, the victim is the lowest-numbered invalid way. Otherwise the victim is lru[index].
    - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
  - pmem_resp in CHECK is ignored.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim line. Hold all three stable until pmem_resp.
  - On pmem_resp: clear the victim's dirty bit and go to FILL.
- FILL:
  - pmem_read=1, pmem_address={req tag, index, 4'h0}.
  - On pmem_resp, at that edge: victim line = pmem_rdata, tag = req tag, valid=1, dirty=0. Then go to CHECK.
  - Back in CHECK the request hits and completes as above. Miss latency is 1 cycle plus memory time(s); mem_resp is never asserted in WRITEBACK or FILL.
- The victim way is latched on leaving CHECK and held through WRITEBACK and FILL.
- If the CPU drops its request mid-miss, the writeback/fill still completes, and the block returns to CHECK with no mem_resp.
- pmem_read and pmem_write are never high together.
- Address changes during a miss are illegal; the request tag and index are latched on leaving CHECK.

Test Plan:
- Cold read miss: reset, then read 0x1234. Required: FILL with pmem_read=1 and pmem_address=0x1230 (no writeback). After pmem_resp with rdata=0x00112233445566778899AABBCCDDEEFF, the next cycle shows mem_resp=1, hit_way=0, byte_offset=4, and way0_data equal to that rdata.
- Write hit with byte enables: following the cold miss, write 0x1236 with wdata=0xBEEF and be=2'b10. Required: mem_resp the same cycle, then line bits [63:56]=0xBE, bits [55:48] unchanged, and dirty[3]=1.
- Second way and LRU: read 0x5230, which is the same set with a different tag. Required: fill into way1, hit_way=1, lru=0. Then read 0x1230, which hits way0 and sets lru=1.
- Dirty eviction: with way0 dirty and lru=0, read 0x9230. Required: pmem_write=1 with pmem_address=0x1230 and the modified line, then pmem_read with pmem_address=0x9230, then a hit in way0 with dirty=0.
- Reset mid-fill: assert reset_n=0 while pmem_read=1. Required: pmem_read=0 and mem_resp=0 immediately, and all valid bits 0. A following read of 0x1234 misses again.
- Dropped request: deassert mem_read during FILL. Required: the fill completes and the line becomes valid, and mem_resp is never pulsed.

Source files
------------

// File: rtl/cache_line_store.sv
// cache_line_store
// ----------------
// Two-way set-associative line storage and miss controller for the LC-3b L1
// cache. It holds the tags, valid, dirty and LRU state plus both ways'
// 128-bit lines. It resolves hits, and on a miss it runs a writeback of a
// dirty victim followed by a fill from physical memory.
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   mem_address      CPU byte address (offset [3:0], index, tag)
//   mem_read         CPU read request, held until mem_resp
//   mem_write        CPU write request, held until mem_resp (wins over read)
//   mem_wdata        CPU write word
//   mem_byte_enable  CPU write byte lanes, bit0 = low byte
//   mem_resp         one-cycle completion pulse (only in CHECK, on a hit)
//   way0_data        way0 line of the indexed set
//   way1_data        way1 line of the indexed set
//   hit_way          way that hit, 0 when there is no hit
//   byte_offset      mem_address[3:0] passed to the read mux
//   pmem_address     line address toward physical memory
//   pmem_read        fill request, held until pmem_resp
//   pmem_write       writeback request, held until pmem_resp
//   pmem_wdata       victim line being written back
//   pmem_rdata       fill line from physical memory
//   pmem_resp        physical memory done pulse

module cache_line_store #(
  parameter int SET_BITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_wdata,
  input  logic [1:0]   mem_byte_enable,
  output logic         mem_resp,
  output logic [127:0] way0_data,
  output logic [127:0] way1_data,
  output logic         hit_way,
  output logic [3:0]   byte_offset,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int NSETS = 1 << SET_BITS;
  localparam int TAG_W = 12 - SET_BITS;

  typedef enum logic [1:0] {
    S_CHECK,
    S_WRITEBACK,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Storage arrays, indexed [way][set]
  logic [127:0]      r_data  [2][NSETS];
  logic [TAG_W-1:0]  r_tag   [2][NSETS];
  logic [NSETS-1:0]  r_valid [2];
  logic [NSETS-1:0]  r_dirty [2];
  logic [NSETS-1:0]  r_lru;

  // Miss context captured when leaving CHECK
  logic                r_victim;
  logic [SET_BITS-1:0] r_index;
  logic [TAG_W-1:0]    r_reqTag;

  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_reqTag;
  logic                w_req;
  logic                w_hit0;
  logic                w_hit1;
  logic                w_anyHit;
  logic                w_hitWay;
  logic                w_victim;
  logic                w_victimDirty;
  logic                w_missStart;
  logic [6:0]          w_wordBase;
  logic [127:0]        w_mergedLine;

  assign w_index  = mem_address[3+SET_BITS:4];
  assign w_reqTag = mem_address[15:4+SET_BITS];
  assign w_req    = mem_read | mem_write;

  assign way0_data   = r_data[0][w_index];
  assign way1_data   = r_data[1][w_index];
  assign byte_offset = mem_address[3:0];

  // Both ways matching is illegal; way0 takes priority if it ever happens
  assign w_hit0   = r_valid[0][w_index] && (r_tag[0][w_index] == w_reqTag);
  assign w_hit1   = r_valid[1][w_index] && (r_tag[1][w_index] == w_reqTag);
  assign w_anyHit = w_hit0 | w_hit1;
  assign w_hitWay = ~w_hit0 & w_hit1;

  // Fill an empty way first (lowest-numbered), otherwise evict the LRU way
  assign w_victim = !r_valid[0][w_index] ? 1'b0 :
                    !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];
  assign w_victimDirty = r_valid[w_victim][w_index] & r_dirty[w_victim][w_index];

  assign w_missStart = (r_state == S_CHECK) && w_req && !w_anyHit;

  // Byte-lane merge of the CPU write word into the hit line
  assign w_wordBase = {mem_address[3:1], 4'b0000};

  always_comb begin
    w_mergedLine = w_hitWay ? way1_data : way0_data;
    if (mem_byte_enable[0])
      w_mergedLine[w_wordBase +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1])
      w_mergedLine[w_wordBase + 7'd8 +: 8] = mem_wdata[15:8];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_CHECK;
    else
      r_state <= w_nextState;
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_CHECK: begin
        if (w_missStart)
          w_nextState = w_victimDirty ? S_WRITEBACK : S_FILL;
      end
      S_WRITEBACK: begin
        if (pmem_resp)
          w_nextState = S_FILL;
      end
      S_FILL: begin
        if (pmem_resp)
          w_nextState = S_CHECK;
      end
      default: w_nextState = S_CHECK;
    endcase
  end

  // Output logic; pmem signals come only from the captured miss context so
  // they stay stable for the whole memory transaction
  always_comb begin
    mem_resp     = 1'b0;
    hit_way      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'h0000;
    pmem_wdata   = '0;
    case (r_state)
      S_CHECK: begin
        if (w_req && w_anyHit) begin
          mem_resp = 1'b1;
          hit_way  = w_hitWay;
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[r_victim][r_index], r_index, 4'h0};
        pmem_wdata   = r_data[r_victim][r_index];
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_reqTag, r_index, 4'h0};
      end
      default: ;
    endcase
  end

  // Miss context capture on the edge that leaves CHECK
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_victim <= 1'b0;
      r_index  <= '0;
      r_reqTag <= '0;
    end else if (w_missStart) begin
      r_victim <= w_victim;
      r_index  <= w_index;
      r_reqTag <= w_reqTag;
    end
  end

  // Array updates: hits update LRU (and data/dirty on writes), a finished
  // writeback cleans the victim, a finished fill installs the new line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSETS; s++) begin
        r_data[0][s] <= '0;
        r_data[1][s] <= '0;
        r_tag[0][s]  <= '0;
        r_tag[1][s]  <= '0;
      end
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      case (r_state)
        S_CHECK: begin
          if (w_req && w_anyHit) begin
            r_lru[w_index] <= ~w_hitWay;
            if (mem_write) begin
              r_data[w_hitWay][w_index]  <= w_mergedLine;
              r_dirty[w_hitWay][w_index] <= 1'b1;
            end
          end
        end
        S_WRITEBACK: begin
          if (pmem_resp)
            r_dirty[r_victim][r_index] <= 1'b0;
        end
        S_FILL: begin
          if (pmem_resp) begin
            r_data[r_victim][r_index]  <= pmem_rdata;
            r_tag[r_victim][r_index]   <= r_reqTag;
            r_valid[r_victim][r_index] <= 1'b1;
            r_dirty[r_victim][r_index] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_store.sv
// Testbench for cache_line_store: directed scenarios followed by randomized
// accesses, all checked against a flat memory image plus a per-set model of
// which lines are resident, dirty and least recently used.

module tb_cache_line_store;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic         mem_resp;
  logic [127:0] way0_data;
  logic [127:0] way1_data;
  logic         hit_way;
  logic [3:0]   byte_offset;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int assertCount = 0;
  int failCount   = 0;

  // CPU-visible memory image keyed by line address
  logic [127:0] golden [int];

  // Residency model per set and way
  logic       mValid [8][2];
  logic [8:0] mTag   [8][2];
  logic       mDirty [8][2];
  int         mLru   [8];

  logic [8:0] tagPool [4];

  cache_line_store #(.SET_BITS(3)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .way0_data       (way0_data),
    .way1_data       (way1_data),
    .hit_way         (hit_way),
    .byte_offset     (byte_offset),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic rd, input logic wr,
                               input logic [15:0] wdata, input logic [1:0] be);
    mem_address     = addr;
    mem_read        = rd;
    mem_write       = wr;
    mem_wdata       = wdata;
    mem_byte_enable = be;
  endtask

  task automatic ensureLine(input logic [15:0] la);
    if (!golden.exists(int'(la)))
      golden[int'(la)] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic resetModel();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        mValid[s][w] = 1'b0;
        mTag[s][w]   = '0;
        mDirty[s][w] = 1'b0;
      end
      mLru[s] = 0;
    end
  endtask

  function automatic logic [127:0] expWay(input int s, input int w);
    logic [2:0] s3;
    s3 = s[2:0];
    if (mValid[s][w])
      return golden[int'({mTag[s][w], s3, 4'h0})];
    return '0;
  endfunction

  task automatic modelWrite(input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [1:0] be);
    logic [15:0]  la;
    logic [127:0] line;
    int           word;
    la   = {addr[15:4], 4'h0};
    line = golden[int'(la)];
    word = int'(addr[3:1]);
    if (be[0]) line[word*16 +: 8]     = wdata[7:0];
    if (be[1]) line[word*16 + 8 +: 8] = wdata[15:8];
    golden[int'(la)] = line;
  endtask

  // One-cycle memory response, issued from just after a falling edge
  task automatic pulseResp();
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
  endtask

  // One CPU access, entered and left just after a falling edge
  task automatic doAccess(input logic [15:0] addr, input bit isWrite,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input bit dropReq, input int lat);
    logic [2:0]  s;
    logic [8:0]  t;
    logic [15:0] la;
    logic [15:0] vla;
    int          hw;
    int          vic;
    bit          hit;
    s  = addr[6:4];
    t  = addr[15:7];
    la = {addr[15:4], 4'h0};
    ensureLine(la);
    hit = 1'b0;
    hw  = 0;
    if (mValid[s][0] && mTag[s][0] == t) begin
      hit = 1'b1; hw = 0;
    end else if (mValid[s][1] && mTag[s][1] == t) begin
      hit = 1'b1; hw = 1;
    end
    applyStimulus(addr, !isWrite, isWrite, wdata, be);
    #1;
    if (!hit) begin
      checkOutput("missNoResp", mem_resp, 0);
      vic = !mValid[s][0] ? 0 : (!mValid[s][1] ? 1 : mLru[s]);
      @(negedge clk); #1;
      if (mValid[s][vic] && mDirty[s][vic]) begin
        vla = {mTag[s][vic], s, 4'h0};
        checkOutput("wbWrite", pmem_write, 1);
        checkOutput("wbNoRead", pmem_read, 0);
        checkOutput("wbAddr", pmem_address, vla);
        checkOutput("wbData", pmem_wdata, golden[int'(vla)]);
        checkOutput("wbNoResp", mem_resp, 0);
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        repeat (lat) begin @(negedge clk); #1; end
        if (lat > 0) begin
          checkOutput("wbHeldAddr", {pmem_write, pmem_address}, {1'b1, vla});
          checkOutput("wbHeldData", pmem_wdata, golden[int'(vla)]);
        end
        pulseResp();
        mDirty[s][vic] = 1'b0;
      end
      checkOutput("fillRead", pmem_read, 1);
      checkOutput("fillNoWrite", pmem_write, 0);
      checkOutput("fillAddr", pmem_address, la);
      checkOutput("fillNoResp", mem_resp, 0);
      if (dropReq) applyStimulus(addr, 1'b0, 1'b0, wdata, be);
      repeat (lat) begin @(negedge clk); #1; end
      pmem_rdata = golden[int'(la)];
      pulseResp();
      mValid[s][vic] = 1'b1;
      mTag[s][vic]   = t;
      mDirty[s][vic] = 1'b0;
      hw = vic;
      if (dropReq) begin
        checkOutput("dropNoResp", mem_resp, 0);
        checkOutput("dropIdle", {pmem_read, pmem_write}, 0);
      end
    end
    if (hit || !dropReq) begin
      checkOutput("hitResp", mem_resp, 1);
      checkOutput("hitWay", hit_way, hw[0]);
      checkOutput("byteOffset", byte_offset, addr[3:0]);
      checkOutput("way0Data", way0_data, expWay(int'(s), 0));
      checkOutput("way1Data", way1_data, expWay(int'(s), 1));
      checkOutput("hitNoPmem", {pmem_read, pmem_write}, 0);
      @(negedge clk);
      mLru[s] = (hw == 0) ? 1 : 0;
      if (isWrite) begin
        modelWrite(addr, wdata, be);
        mDirty[s][hw] = 1'b1;
      end
      applyStimulus(addr, 1'b0, 1'b0, 16'h0000, 2'b00);
      #1;
      checkOutput("respPulse", mem_resp, 0);
    end
  endtask

  initial begin
    logic [15:0] addr;
    tagPool[0] = 9'h024;
    tagPool[1] = 9'h0A4;
    tagPool[2] = 9'h124;
    tagPool[3] = 9'h1FF;
    resetModel();

    // Reset state
    reset_n    = 1'b0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);
    #2;
    checkOutput("rstResp", mem_resp, 0);
    checkOutput("rstPmemRd", pmem_read, 0);
    checkOutput("rstPmemWr", pmem_write, 0);
    checkOutput("rstHitWay", hit_way, 0);
    checkOutput("rstPmemAddr", pmem_address, 0);
    checkOutput("rstPmemData", pmem_wdata, 0);
    checkOutput("rstWay0", way0_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // Cold read miss into way0
    golden[int'(16'h1230)] = 128'h00112233445566778899AABBCCDDEEFF;
    doAccess(16'h1234, 1'b0, 16'h0000, 2'b00, 1'b0, 2);

    // Write hit, only the high lane of word 3
    doAccess(16'h1236, 1'b1, 16'hBEEF, 2'b10, 1'b0, 0);
    checkOutput("wrLanes", way0_data[63:48], 16'hBE99);

    // Second way and LRU
    doAccess(16'h5230, 1'b0, 16'h0000, 2'b00, 1'b0, 1);
    doAccess(16'h1230, 1'b0, 16'h0000, 2'b00, 1'b0, 0);
    doAccess(16'h5230, 1'b0, 16'h0000, 2'b00, 1'b0, 0);

    // Dirty eviction of way0 (lru points at way0)
    doAccess(16'h9230, 1'b0, 16'h0000, 2'b00, 1'b0, 3);
    doAccess(16'h9238, 1'b0, 16'h0000, 2'b00, 1'b0, 0);
    // Evicting way1 (clean) next must not write back
    doAccess(16'h1230, 1'b0, 16'h0000, 2'b00, 1'b0, 1);

    // Dropped request during fill
    doAccess(16'h2340, 1'b0, 16'h0000, 2'b00, 1'b1, 2);
    doAccess(16'h2342, 1'b0, 16'h0000, 2'b00, 1'b0, 0);

    // Reset in the middle of a fill
    applyStimulus(16'h3454, 1'b1, 1'b0, 16'h0000, 2'b00);
    @(negedge clk); #1;
    checkOutput("preRstFill", pmem_read, 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midRstRead", pmem_read, 0);
    checkOutput("midRstResp", mem_resp, 0);
    checkOutput("midRstWay0", way0_data, 0);
    checkOutput("midRstWay1", way1_data, 0);
    applyStimulus(16'h1234, 1'b0, 1'b0, 16'h0000, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    resetModel();
    #1;
    doAccess(16'h1234, 1'b0, 16'h0000, 2'b00, 1'b0, 1);

    // Randomized accesses over a few sets and tags to force conflicts
    for (int n = 0; n < 300; n++) begin
      addr = {tagPool[$urandom_range(0, 3)], 3'($urandom_range(0, 2)),
              4'($urandom_range(0, 15))};
      doAccess(addr, ($urandom_range(0, 9) < 4), 16'($urandom),
               2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
               $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
